// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: core reset sequencer with run/event counters and halt/drain/watchdog run termination
//   in:  clk, rst_n (async active-low), halt_req, evt[NUM_CH]
//   out: cpu_rst, state (0 HOLD,1 RUN,2 DRAIN,3 DONE), cycle_cnt, evt_cnt (ch i at [i*CNT_WIDTH +: CNT_WIDTH]), done, timeout
module sim_run_ctrl #(
  parameter int     RST_CYCLES   = 25,
  parameter int     CNT_WIDTH    = 32,
  parameter int     NUM_CH       = 4,
  parameter int     DRAIN_CYCLES = 16,
  parameter longint TIMEOUT      = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        halt_req,
  input  logic [NUM_CH-1:0]           evt,
  output logic                        cpu_rst,
  output logic [1:0]                  state,
  output logic [CNT_WIDTH-1:0]        cycle_cnt,
  output logic [NUM_CH*CNT_WIDTH-1:0] evt_cnt,
  output logic                        done,
  output logic                        timeout
);
  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam int HM0 = RST_CYCLES > DRAIN_CYCLES ? RST_CYCLES : DRAIN_CYCLES;
  localparam int HW = $clog2(HM0 > 2 ? HM0 : 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [HW-1:0] DRAIN_LAST = HW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);
  state_t r_state, w_nxt;
  logic [HW-1:0] r_hold, r_drain;
  logic [CNT_WIDTH-1:0] r_cycle;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] r_evt;
  logic r_cpu_rst, r_done, r_timeout, w_to, w_wd;
  // watchdog compares before the increment so cycle_cnt lands exactly on TIMEOUT
  assign w_wd = (TIMEOUT != 0) && (r_cycle == TO_LAST);
  always_comb begin
    w_nxt = r_state;
    w_to = 1'b0;
    case (r_state)
      S_HOLD:  w_nxt = (r_hold == HOLD_LAST) ? S_RUN : S_HOLD;
      S_RUN: begin
        if (halt_req) w_nxt = (DRAIN_CYCLES > 0) ? S_DRAIN : S_DONE;
        else if (w_wd) begin
          w_nxt = S_DONE;
          w_to = 1'b1;
        end
      end
      S_DRAIN: w_nxt = (r_drain == DRAIN_LAST) ? S_DONE : S_DRAIN;
      default: w_nxt = S_DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_HOLD;
    else r_state <= w_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hold <= '0;
      r_drain <= '0;
      r_cpu_rst <= 1'b1;
      r_cycle <= '0;
      r_evt <= '0;
      r_done <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_cpu_rst <= w_nxt == S_HOLD;
      r_done <= w_nxt == S_DONE;
      r_timeout <= r_timeout | w_to;
      r_hold <= (r_state == S_HOLD) ? r_hold + 1'b1 : r_hold;
      r_drain <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;
      if ((r_state == S_RUN || r_state == S_DRAIN) && !(&r_cycle)) r_cycle <= r_cycle + 1'b1;
      for (int i = 0; i < NUM_CH; i++)
        if (r_state == S_RUN && evt[i] && !(&r_evt[i])) r_evt[i] <= r_evt[i] + 1'b1;
    end
  assign cpu_rst = r_cpu_rst;
  assign state = r_state;
  assign cycle_cnt = r_cycle;
  assign evt_cnt = r_evt;
  assign done = r_done;
  assign timeout = r_timeout;
`ifndef SYNTHESIS
  // a watchdog limit wider than the cycle counter could never be reached
  always @(posedge clk)
    assert (CNT_WIDTH >= 63 || (TIMEOUT >> CNT_WIDTH) == 0)
      else $error("sim_run_ctrl: TIMEOUT does not fit in CNT_WIDTH bits");
`endif
endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: scoreboard bench for sim_run_ctrl across default, watchdog and narrow-counter configurations
module tb_sim_run_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, halt_a, cpu_rst_a, done_a, to_a;
  logic [3:0] evt_a;
  logic [1:0] state_a;
  logic [31:0] cyc_a;
  logic [127:0] ev_a;
  logic rst_b, halt_b, cpu_rst_b, done_b, to_b;
  logic [3:0] evt_b;
  logic [1:0] state_b;
  logic [31:0] cyc_b;
  logic [127:0] ev_b;
  logic rst_c, halt_c, cpu_rst_c, done_c, to_c;
  logic [1:0] evt_c;
  logic [1:0] state_c;
  logic [3:0] cyc_c;
  logic [7:0] ev_c;
  sim_run_ctrl u_a (
    .clk(clk), .rst_n(rst_a), .halt_req(halt_a), .evt(evt_a), .cpu_rst(cpu_rst_a),
    .state(state_a), .cycle_cnt(cyc_a), .evt_cnt(ev_a), .done(done_a), .timeout(to_a)
  );
  sim_run_ctrl #(.RST_CYCLES(3), .DRAIN_CYCLES(4), .TIMEOUT(50)) u_b (
    .clk(clk), .rst_n(rst_b), .halt_req(halt_b), .evt(evt_b), .cpu_rst(cpu_rst_b),
    .state(state_b), .cycle_cnt(cyc_b), .evt_cnt(ev_b), .done(done_b), .timeout(to_b)
  );
  sim_run_ctrl #(.RST_CYCLES(2), .CNT_WIDTH(4), .NUM_CH(2), .DRAIN_CYCLES(0)) u_c (
    .clk(clk), .rst_n(rst_c), .halt_req(halt_c), .evt(evt_c), .cpu_rst(cpu_rst_c),
    .state(state_c), .cycle_cnt(cyc_c), .evt_cnt(ev_c), .done(done_c), .timeout(to_c)
  );
  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  task automatic push(input string tag, input logic [63:0] exp);
    sb.push_back('{tag, exp});
  endtask
  task automatic pop(input logic [63:0] obs);
    exp_t x;
    if (sb.size() == 0) begin
      $display("FAIL sb_underflow: no expectation queued for %0h", obs);
      $fatal(1);
    end
    x = sb.pop_front();
    chk(x.tag, obs, x.exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic idle_a(input string p);
    push({p, "_state"}, 0); push({p, "_cpu_rst"}, 1); push({p, "_cycle"}, 0);
    push({p, "_done"}, 0); push({p, "_timeout"}, 0);
    for (int i = 0; i < 4; i++) push({p, "_evt"}, 0);
    pop(state_a); pop(cpu_rst_a); pop(cyc_a); pop(done_a); pop(to_a);
    for (int i = 0; i < 4; i++) pop(ev_a[i*32 +: 32]);
  endtask
  task automatic hold_a();
    rst_a = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      push("a_hold_state", (k == 25) ? 1 : 0);
      push("a_hold_cpu_rst", (k < 25) ? 1 : 0);
      tick();
      pop(state_a);
      pop(cpu_rst_a);
    end
    push("a_run_cycle0", 0);
    pop(cyc_a);
  endtask
  initial begin
    rst_a = 0; rst_b = 0; rst_c = 0;
    halt_a = 0; halt_b = 0; halt_c = 0;
    evt_a = 0; evt_b = 0; evt_c = 0;
    repeat (3) tick();
    idle_a("a_rst");
    hold_a();
    push("a_evt0", 10); push("a_evt1", 0); push("a_evt2", 10); push("a_evt3", 3); push("a_cyc13", 13);
    evt_a = 4'b0101;
    repeat (10) tick();
    evt_a = 4'b1000;
    repeat (3) tick();
    evt_a = 4'b0000;
    for (int i = 0; i < 4; i++) pop(ev_a[i*32 +: 32]);
    pop(cyc_a);
    push("a_cyc100", 100);
    repeat (87) tick();
    pop(cyc_a);
    push("a_drain_state", 2); push("a_drain_cyc", 101);
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    evt_a = 4'hf;
    pop(state_a); pop(cyc_a);
    push("a_drain_last_state", 2); push("a_drain_last_done", 0); push("a_drain_last_cyc", 116);
    repeat (15) tick();
    pop(state_a); pop(done_a); pop(cyc_a);
    push("a_done_state", 3); push("a_done", 1); push("a_done_to", 0);
    push("a_done_cyc", 117); push("a_done_cpu_rst", 0);
    push("a_frz_evt0", 10); push("a_frz_evt1", 0); push("a_frz_evt2", 10); push("a_frz_evt3", 3);
    tick();
    pop(state_a); pop(done_a); pop(to_a); pop(cyc_a); pop(cpu_rst_a);
    for (int i = 0; i < 4; i++) pop(ev_a[i*32 +: 32]);
    push("a_term_state", 3); push("a_term_cyc", 117); push("a_term_evt1", 0);
    halt_a = 1'b1;
    repeat (5) tick();
    halt_a = 1'b0;
    evt_a = 4'h0;
    pop(state_a); pop(cyc_a); pop(ev_a[63:32]);
    rst_a = 1'b0;
    tick();
    hold_a();
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    evt_a = 4'hf;
    push("a_mid_state", 2); push("a_mid_cyc", 4);
    repeat (3) tick();
    pop(state_a); pop(cyc_a);
    #1 rst_a = 1'b0;
    #1 idle_a("a_async");
    tick();
    idle_a("a_held");
    evt_a = 4'h0;
    hold_a();
    rst_b = 1'b1;
    push("b_run_state", 1);
    repeat (3) tick();
    pop(state_b);
    push("b_pre_state", 1); push("b_pre_cyc", 49);
    repeat (49) tick();
    pop(state_b); pop(cyc_b);
    push("b_wd_state", 3); push("b_wd_to", 1); push("b_wd_done", 1);
    push("b_wd_cyc", 50); push("b_wd_cpu_rst", 0);
    tick();
    pop(state_b); pop(to_b); pop(done_b); pop(cyc_b); pop(cpu_rst_b);
    push("b_wd_frz_cyc", 50); push("b_wd_frz_to", 1);
    repeat (3) tick();
    pop(cyc_b); pop(to_b);
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    repeat (52) tick();
    push("b_h_pre_cyc", 49);
    pop(cyc_b);
    halt_b = 1'b1;
    push("b_h_state", 2); push("b_h_to", 0); push("b_h_cyc", 50);
    tick();
    halt_b = 1'b0;
    pop(state_b); pop(to_b); pop(cyc_b);
    push("b_h_drain_state", 2); push("b_h_drain_cyc", 53);
    repeat (3) tick();
    pop(state_b); pop(cyc_b);
    push("b_h_done_state", 3); push("b_h_done", 1); push("b_h_done_to", 0); push("b_h_done_cyc", 54);
    tick();
    pop(state_b); pop(done_b); pop(to_b); pop(cyc_b);
    rst_c = 1'b1;
    push("c_run_state", 1);
    repeat (2) tick();
    pop(state_c);
    push("c_sat_evt0", 15); push("c_sat_evt1", 0); push("c_sat_cyc", 15);
    evt_c = 2'b01;
    repeat (20) tick();
    evt_c = 2'b00;
    pop(ev_c[3:0]); pop(ev_c[7:4]); pop(cyc_c);
    push("c_done_state", 3); push("c_done", 1); push("c_done_to", 0); push("c_done_cyc", 15);
    halt_c = 1'b1;
    tick();
    halt_c = 1'b0;
    pop(state_c); pop(done_c); pop(to_c); pop(cyc_c);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
